// File: rtl/cube_pkg.sv
// Shared move encodings, scramble FSM state type and LFSR helpers for the cube
// move path.
package cube_pkg;
    localparam logic [2:0] FACE_U    = 3'd0;
    localparam logic [2:0] FACE_L    = 3'd1;
    localparam logic [2:0] FACE_F    = 3'd2;
    localparam logic [2:0] FACE_R    = 3'd3;
    localparam logic [2:0] FACE_B    = 3'd4;
    localparam logic [2:0] FACE_D    = 3'd5;
    localparam logic [2:0] FACE_NONE = 3'd7;

    localparam logic [1:0] ROT_NONE = 2'd0;
    localparam logic [1:0] ROT_CW   = 2'd1;
    localparam logic [1:0] ROT_HALF = 2'd2;
    localparam logic [1:0] ROT_CCW  = 2'd3;

    localparam logic [2:0]  NUM_FACES = 3'd6;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {ST_IDLE, ST_SCRAMBLE} seq_state_t;

    typedef struct packed {
        logic [2:0] face;
        logic [1:0] rot;
    } move_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], ^(l & LFSR_TAPS)};
    endfunction

    // Folds the low LFSR bits into a legal move that never repeats prev's face.
    function automatic move_t scramble_move(input logic [4:0] bits, input logic [2:0] prev);
        move_t m;
        m.face = (bits[2:0] >= NUM_FACES) ? bits[2:0] - NUM_FACES : bits[2:0];
        if (m.face == prev)
            m.face = (m.face == NUM_FACES - 3'd1) ? FACE_U : m.face + 3'd1;
        m.rot = (bits[4:3] == ROT_NONE) ? ROT_CW : bits[4:3];
        return m;
    endfunction
endpackage

// File: rtl/move_sequencer_if.sv
// Bus between the move source (user/bench) and the move sequencer.
// Handshake: a move transfers on a clk edge where move_valid && move_ready; move_ready depends only on FIFO occupancy.
interface move_sequencer_if #(parameter int DEPTH = 8);
    import cube_pkg::*;

    logic                         move_valid;
    logic [2:0]                   move_face;
    logic [1:0]                   move_rot;
    logic                         move_ready;
    logic                         scramble_start;
    logic                         busy;
    logic [$clog2(DEPTH+1)-1:0]   fifo_count;
    logic                         err_drop;
    logic [5:0]                   nextFaceMove;
    logic [2:0]                   nextRotation;
    logic                         issue;
    seq_state_t                   dbg_state;

    modport master (
        output move_valid, move_face, move_rot, scramble_start,
        input  move_ready, busy, fifo_count, err_drop, nextFaceMove, nextRotation, issue, dbg_state
    );

    modport slave (
        input  move_valid, move_face, move_rot, scramble_start,
        output move_ready, busy, fifo_count, err_drop, nextFaceMove, nextRotation, issue, dbg_state
    );
endinterface

// File: rtl/move_fifo.sv
// DEPTH-entry synchronous FIFO of packed moves; combinational head read.
// Callers must not push when full or pop when empty.
module move_fifo
    import cube_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  move_t                      din,
    input  logic                       pop,
    output move_t                      dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    move_t           mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
endmodule

// File: rtl/move_sequencer.sv
// Feeds the cube state block one registered move per clock: scramble moves
// from an LFSR take priority over user moves buffered in a FIFO.
module move_sequencer
    import cube_pkg::*;
#(
    parameter int          DEPTH        = 8,
    parameter int          SCRAMBLE_LEN = 20,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    move_sequencer_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);

    seq_state_t      state;
    logic [7:0]      remaining;
    logic [15:0]     lfsr;
    logic [2:0]      prev_face;
    move_t           out_mv;
    logic            issue_q;
    logic            err_q;

    logic            full;
    logic            empty;
    logic [CW-1:0]   count;
    move_t           head;
    move_t           user_mv;
    move_t           scr_mv;
    logic            scrambling;
    logic            legal;
    logic            accept;
    logic            push;
    logic            pop;

    assign user_mv    = '{face: bus.move_face, rot: bus.move_rot};
    assign scrambling = (state == ST_SCRAMBLE);
    assign legal      = (bus.move_face < NUM_FACES) && (bus.move_rot != ROT_NONE);
    assign accept     = bus.move_valid && !full;
    assign push       = accept && legal;
    // The FIFO is frozen while a scramble owns the output.
    assign pop        = !scrambling && !empty;
    assign scr_mv     = scramble_move(lfsr[4:0], prev_face);

    move_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (user_mv),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            remaining <= '0;
            lfsr      <= LFSR_SEED;
            prev_face <= FACE_NONE;
            out_mv    <= '0;
            issue_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q   <= accept && !legal;
            issue_q <= scrambling || !empty;

            case (state)
                ST_IDLE: begin
                    if (bus.scramble_start) begin
                        state     <= ST_SCRAMBLE;
                        remaining <= 8'(SCRAMBLE_LEN);
                    end
                end
                ST_SCRAMBLE: begin
                    remaining <= remaining - 8'd1;
                    lfsr      <= lfsr_step(lfsr);
                    if (remaining == 8'd1)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            if (scrambling) begin
                out_mv    <= scr_mv;
                prev_face <= scr_mv.face;
            end else if (!empty) begin
                out_mv    <= head;
                prev_face <= head.face;
            end else begin
                out_mv    <= '0;
            end
        end
    end

    assign bus.move_ready   = !full;
    assign bus.busy         = scrambling;
    assign bus.fifo_count   = count;
    assign bus.err_drop     = err_q;
    assign bus.nextFaceMove = {3'b000, out_mv.face};
    assign bus.nextRotation = {1'b0, out_mv.rot};
    assign bus.issue        = issue_q;
    assign bus.dbg_state    = state;
endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer: user moves and a reference LFSR
// scramble model feed an expected queue drained by an output monitor.
module tb_move_sequencer;
  import cube_pkg::*;

  localparam int          DEPTH = 8;
  localparam int          SLEN  = 20;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  move_sequencer_if #(.DEPTH(DEPTH)) bus();

  move_sequencer #(.DEPTH(DEPTH), .SCRAMBLE_LEN(SLEN), .LFSR_SEED(SEED)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [4:0]  exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          issue_cnt = 0;
  int          busy_cnt = 0;
  int          first_issue_cyc = -1;
  bit          mon_on = 0;
  logic [15:0] tb_lfsr = SEED;
  int          tb_prev = 7;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference scramble generator, independent of the RTL helpers.
  task automatic gen_scramble(input int n);
    for (int i = 0; i < n; i++) begin
      int f;
      int r;
      f = int'(tb_lfsr[2:0]);
      if (f > 5) f = f - 6;
      if (f == tb_prev) f = (f + 1) % 6;
      r = int'(tb_lfsr[4:3]);
      if (r == 0) r = 1;
      exp_q.push_back({3'(f), 2'(r)});
      tb_prev = f;
      tb_lfsr = {tb_lfsr[14:0], tb_lfsr[15] ^ tb_lfsr[13] ^ tb_lfsr[12] ^ tb_lfsr[10]};
    end
  endtask

  task automatic offer(input logic [2:0] f, input logic [1:0] r, input bit store);
    bus.move_valid = 1'b1;
    bus.move_face  = f;
    bus.move_rot   = r;
    @(posedge clk); #1;
    bus.move_valid = 1'b0;
    if (store) begin
      exp_q.push_back({f, r});
      tb_prev = int'(f);
    end
  endtask

  task automatic pulse_start();
    bus.scramble_start = 1'b1;
    @(posedge clk); #1;
    bus.scramble_start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain_in_budget", 32'(n < budget), 32'd1);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mon_on) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.issue === 1'b1) begin
        logic [4:0] e;
        issue_cnt++;
        if (first_issue_cyc < 0) first_issue_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_issue", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("face", 32'(bus.nextFaceMove), 32'(e[4:2]));
          check("rot", 32'(bus.nextRotation), 32'(e[1:0]));
        end
      end else begin
        check("idle_rot", 32'(bus.nextRotation), 32'd0);
      end
    end
  end

  initial begin
    int c0;
    int ok;
    bus.move_valid     = 1'b0;
    bus.move_face      = '0;
    bus.move_rot       = '0;
    bus.scramble_start = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(bus.move_ready), 32'd1);
    check("rst_count", 32'(bus.fifo_count), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_err", 32'(bus.err_drop), 32'd0);
    check("rst_face", 32'(bus.nextFaceMove), 32'd0);
    check("rst_rot", 32'(bus.nextRotation), 32'd0);
    check("rst_issue", 32'(bus.issue), 32'd0);
    mon_on = 1;
    @(posedge clk); #1;

    // Three user moves back to back, first output two cycles after first push
    c0 = cyc;
    first_issue_cyc = -1;
    offer(FACE_F, ROT_CW, 1);
    offer(FACE_R, ROT_CCW, 1);
    offer(FACE_U, ROT_HALF, 1);
    wait_drain(40);
    check("first_latency", 32'(first_issue_cyc - c0), 32'd2);
    check("after_drain_rot", 32'(bus.nextRotation), 32'd0);

    // Illegal moves are dropped with an err_drop pulse
    offer(3'd6, ROT_CW, 0);
    @(negedge clk);
    check("err_face", 32'(bus.err_drop), 32'd1);
    offer(FACE_F, ROT_NONE, 0);
    @(negedge clk);
    check("err_rot", 32'(bus.err_drop), 32'd1);
    @(negedge clk);
    check("err_clear", 32'(bus.err_drop), 32'd0);
    check("err_count", 32'(bus.fifo_count), 32'd0);
    wait_drain(20);

    // Plain scramble from the reset seed
    issue_cnt = 0;
    busy_cnt  = 0;
    pulse_start();
    gen_scramble(SLEN);
    wait_drain(200);
    check("scr_issues", 32'(issue_cnt), 32'(SLEN));
    check("scr_busy_cycles", 32'(busy_cnt), 32'(SLEN));

    // Pushes during a scramble wait for it; a second start is ignored
    issue_cnt = 0;
    busy_cnt  = 0;
    pulse_start();
    gen_scramble(SLEN);
    for (int i = 0; i < 3; i++)
      offer(3'($urandom_range(0, 5)), 2'($urandom_range(1, 3)), 1);
    pulse_start();
    wait_drain(200);
    check("mid_issues", 32'(issue_cnt), 32'(SLEN + 3));
    check("mid_busy_cycles", 32'(busy_cnt), 32'(SLEN));

    // Fill the FIFO while the scramble blocks draining
    pulse_start();
    gen_scramble(SLEN);
    for (int i = 0; i < DEPTH; i++)
      offer(3'($urandom_range(0, 5)), 2'($urandom_range(1, 3)), 1);
    @(negedge clk);
    check("full_count", 32'(bus.fifo_count), 32'(DEPTH));
    check("full_ready", 32'(bus.move_ready), 32'd0);
    offer(FACE_B, ROT_HALF, 0);
    @(negedge clk);
    check("full_refused", 32'(bus.fifo_count), 32'(DEPTH));
    check("full_still_busy", 32'(bus.busy), 32'd1);
    wait_drain(200);

    // Reset mid-scramble with two entries queued
    issue_cnt = 0;
    pulse_start();
    gen_scramble(SLEN);
    offer(FACE_L, ROT_CW, 1);
    offer(FACE_D, ROT_HALF, 1);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      if (issue_cnt >= 7) begin
        ok = 1;
        break;
      end
    end
    check("reach_move7", 32'(ok), 32'd1);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    tb_lfsr = SEED;
    tb_prev = 7;
    @(negedge clk);
    check("rst2_rot", 32'(bus.nextRotation), 32'd0);
    check("rst2_busy", 32'(bus.busy), 32'd0);
    check("rst2_count", 32'(bus.fifo_count), 32'd0);
    check("rst2_issue", 32'(bus.issue), 32'd0);
    issue_cnt = 0;
    repeat (30) @(posedge clk);
    #1;
    check("rst2_quiet", 32'(issue_cnt), 32'd0);

    // LFSR and prev_face restart from reset values
    pulse_start();
    gen_scramble(SLEN);
    wait_drain(200);
    check("reseed_issues", 32'(issue_cnt), 32'(SLEN));
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
- Upstream feeder for the cube state register.
- Buffers user move commands in a small FIFO and, on request, generates a pseudo-random scramble of SCRAMBLE_LEN moves.
- Presents at most one registered move per clock on nextFaceMove/nextRotation, which drive the cube state block directly.
- A rotation of 0 means "no move this cycle".

Parameters:
DEPTH, 8, move FIFO entries (power of 2, >=2)
SCRAMBLE_LEN, 20, moves emitted per scramble (1..255)
LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
move_valid  in  1  user move offered this cycle
move_face  in  3  face code: 0=U 1=L 2=F 3=R 4=B 5=D
move_rot  in  2  1=quarter CW, 2=half, 3=quarter CCW
move_ready  out  1  FIFO can accept; equals !full
scramble_start  in  1  request scramble (single-cycle pulse or level)
busy  out  1  scramble in progress
fifo_count  out  $clog2(DEPTH+1)  entries held
err_drop  out  1  one-cycle pulse: accepted move was illegal and discarded
nextFaceMove  out  6  face to apply; bits [5:3] always 0
nextRotation  out  3  quarter-turn count 0..3; bit 2 always 0
issue  out  1  high when nextRotation != 0

Behaviour:
- Reset, at the first clk edge with rst=1:
  - FIFO empty, fifo_count=0, move_ready=1.
  - busy=0, err_drop=0, nextFaceMove=0, nextRotation=0, issue=0.
  - LFSR=LFSR_SEED, prev_face=7 (none).
- Reset mid-scramble or mid-drain aborts all activity. No further moves are emitted after the reset edge.
- Push:
  - A push occurs when move_valid && move_ready.
  - If move_face>5 or move_rot==0, the move is not stored and err_drop pulses on the next cycle.
  - Otherwise the move is written at the write pointer.
  - Pointers wrap modulo DEPTH.
- move_ready depends only on the current count. A push is refused when full, even if a pop happens in the same cycle.
- Output selection, evaluated each cycle and registered, so outputs are valid one cycle after selection:
  - Priority 1: busy=1. Emit the scramble move, decrement the remaining count, and advance the LFSR.
  - Priority 2: FIFO not empty. Pop the head and emit it.
  - Otherwise emit face=0, rot=0.
- The FIFO is never popped while busy. Pushes continue to be accepted during a scramble.
- Simultaneous push and pop when not full: fifo_count is unchanged and pointers both advance. A push into an empty FIFO can be popped on the following cycle at the earliest (no same-cycle bypass).
- Scramble FSM, states IDLE and SCRAMBLE:
  - IDLE -> SCRAMBLE on scramble_start when busy=0. Sets remaining=SCRAMBLE_LEN and busy=1 on the next edge. The first scramble move appears on the cycle after busy rises.
  - scramble_start while busy is ignored and does not extend the scramble.
  - SCRAMBLE -> IDLE after the cycle that emits the last move (remaining 1->0). busy falls on that same edge.
  - Exactly SCRAMBLE_LEN outputs with issue=1 are produced per scramble.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; shift left, feedback into bit 0. It advances only in SCRAMBLE cycles.
- Scramble move derivation:
  - f = L[2:0]; if f>=6 then f = f-6.
  - If f==prev_face then f = (f+1) mod 6.
  - r = (L[4:3]==0) ? 1 : L[4:3].
  - prev_face updates on every emitted move, FIFO or scramble.
  - Consecutive emitted moves never share a face within a scramble.
- Arithmetic: fifo_count saturates at neither end because flow control prevents overflow. Pointer width is $clog2(DEPTH).

Decomposition:
- Shared package cube_pkg:
  - face codes FACE_U..FACE_D as 3-bit constants.
  - rotation constants ROT_NONE/CW/HALF/CCW.
  - NUM_FACES=6.
  - LFSR tap mask.
- One sub-module, move_fifo: DEPTH x 5-bit synchronous FIFO with push/pop/full/empty/count.
- The FSM, LFSR and output register stay in move_sequencer.

Test Plan:
- Reset, then push (F,1),(R,3),(U,2) on consecutive cycles -> issue pulses with nextFaceMove=2,3,0 and nextRotation=1,3,2, first output 2 cycles after the first push; then rot=0.
- Push DEPTH=8 moves with no drain possible (hold scramble busy) -> move_ready=0 at fifo_count=8; the 9th offer is not accepted and fifo_count stays 8.
- Push face=6 rot=1, then face=2 rot=0 -> err_drop pulses twice, fifo_count stays 0, no issue.
- Pulse scramble_start after reset -> busy high for 20 cycles; exactly 20 issue cycles; all faces 0..5, rot 1..3, no two consecutive equal faces; the sequence matches the golden model from seed 16'hACE1.
- Push 3 moves during a scramble -> they are emitted only after busy falls, in push order; a second scramble_start mid-scramble does not change the total count of 20.
- Assert rst for 1 cycle at scramble move 7 with 2 FIFO entries -> the next cycle shows nextRotation=0, busy=0, fifo_count=0; no further issue until new stimulus.
